mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 23, block address width (one block = 16 bytes).
REQ-002 SHALL have parameter DWIDTH, default 128, block data width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum busy cycles without mem_ready before abort.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports ic_req  input  1  and ic_addr  input  AWIDTH: I-cache block-read request and address.
REQ-007 SHALL have ports ic_ready  output  1  and ic_rdata  output  DWIDTH: I-cache completion pulse and read block.
REQ-008 SHALL have ports dc_req  input  1, dc_we  input  1, dc_addr  input  AWIDTH and dc_wdata  input  DWIDTH: D-cache request, write enable (1 = write, 0 = read), address and write block.
REQ-009 SHALL have ports dc_ready  output  1  and dc_rdata  output  DWIDTH: D-cache completion pulse and read block.
REQ-010 SHALL have ports mem_wren  output  1, mem_rden  output  1, mem_addr  output  AWIDTH and mem_data_in  output  DWIDTH, all driving the shared block memory.
REQ-011 SHALL have ports mem_data_out  input  DWIDTH and mem_ready  input  1, returned by the shared block memory.
REQ-012 SHALL have port err_timeout  output  1, sticky flag set when a transaction is aborted.

Function
REQ-013 SHALL implement states IDLE, IC_BUSY and DC_BUSY; all mem_* and requester outputs SHALL be registered.
REQ-014 In IDLE with exactly one eligible request, SHALL grant it; with both eligible, SHALL grant the requester not granted most recently (round-robin pointer).
REQ-015 On grant, SHALL at the next edge enter the BUSY state and drive mem_addr, mem_data_in (dc_wdata for a D-cache write, else 0) and exactly one of mem_rden/mem_wren high.
REQ-016 mem_wren and mem_rden SHALL never be high simultaneously.
REQ-017 In BUSY, mem_addr, mem_data_in and the enable SHALL be held constant until mem_ready is sampled 1.
REQ-018 On the edge sampling mem_ready=1 in BUSY: deassert both enables, capture mem_data_out into the granted requester's rdata (read only; writes leave rdata unchanged), pulse its ready high for exactly one cycle, update the round-robin pointer, return to IDLE.
REQ-019 SHALL leave mem_rden/mem_wren low for at least one cycle between transactions, so the memory latency counter restarts from zero.
REQ-020 The requester just completed SHALL be ineligible during the IDLE cycle in which its ready is high; requesters keep req, addr, we and wdata stable from req rise until ready.
REQ-021 A 7-bit-minimum busy counter SHALL clear on entering BUSY and increment each BUSY cycle; reaching TIMEOUT without mem_ready SHALL deassert enables, pulse the granted ready with rdata = 0, set err_timeout, return to IDLE.
REQ-022 err_timeout SHALL remain 1 until reset.
REQ-023 mem_ready sampled 1 in IDLE SHALL be ignored.
REQ-024 ic_ready and dc_ready SHALL never be high in the same cycle.
REQ-025 Memory latency SHALL NOT be assumed; nominal transaction = 1 grant cycle + memory latency + 1 completion cycle.

Reset
REQ-026 rst_n low SHALL immediately force IDLE; all outputs, including mem_wren, mem_rden, mem_addr, mem_data_in, ic_ready, dc_ready, ic_rdata, dc_rdata and err_timeout, to 0; busy counter to 0; round-robin pointer favouring D-cache.
REQ-027 Reset asserted mid-transaction SHALL abandon it without a ready pulse.
REQ-028 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-029 ic_req=1, ic_addr=0x000010 alone, memory preloaded with 0xA5 bytes -> mem_rden high one cycle after req, held until mem_ready; ic_ready one-cycle pulse; ic_rdata = {16{8'hA5}}.
REQ-030 dc_req=1, dc_we=1, dc_addr=0x000004, dc_wdata=128'h0123..CDEF, then a D-cache read of the same address -> mem_wren only for the write, dc_rdata=128'h0123..CDEF, rden/wren low at least one cycle between.
REQ-031 ic_req and dc_req rise in the same cycle after reset, both held -> D-cache served first, then I-cache, then D-cache; no back-to-back grant to the same requester while the other waits.
REQ-032 mem_ready tied 0, dc_req=1 -> after TIMEOUT=64 busy cycles, dc_ready pulses with dc_rdata=0, enables low, err_timeout=1 and stays 1.
REQ-033 rst_n pulsed low while in IC_BUSY -> all outputs 0 asynchronously, no ic_ready pulse; a new ic_req after release completes normally.
REQ-034 Assertions throughout: wren&rden never both high, ready signals mutually exclusive, mem_addr stable while enabled.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting an I-cache and a D-cache access to one shared
// block memory, with registered outputs and a busy-cycle timeout.
module mem_arbiter #(
  parameter int AWIDTH  = 23,
  parameter int DWIDTH  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [AWIDTH-1:0] ic_addr,
  output logic              ic_ready,
  output logic [DWIDTH-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [AWIDTH-1:0] dc_addr,
  input  logic [DWIDTH-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [DWIDTH-1:0] dc_rdata,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data_in,
  input  logic [DWIDTH-1:0] mem_data_out,
  input  logic              mem_ready,
  output logic              err_timeout
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 7) ? $clog2(TIMEOUT + 1) : 7;

  typedef enum logic [1:0] {IDLE, IC_BUSY, DC_BUSY} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              prefer_dc, prefer_dc_nx;
  logic              wren_nx, rden_nx;
  logic [AWIDTH-1:0] addr_nx;
  logic [DWIDTH-1:0] wdata_nx, ic_rdata_nx, dc_rdata_nx;
  logic              ic_ready_nx, dc_ready_nx, err_nx;
  logic              ic_elig, dc_elig, expired;

  // A requester whose ready is high this cycle has just been served and sits out.
  assign ic_elig = ic_req && !ic_ready;
  assign dc_elig = dc_req && !dc_ready;
  assign expired = (cnt == CW'(TIMEOUT - 1));

  // NOTE: every signal gets its default before the case; a path that skips an
  // assignment in always_comb would otherwise infer a latch.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    prefer_dc_nx = prefer_dc;
    wren_nx      = mem_wren;
    rden_nx      = mem_rden;
    addr_nx      = mem_addr;
    wdata_nx     = mem_data_in;
    ic_rdata_nx  = ic_rdata;
    dc_rdata_nx  = dc_rdata;
    ic_ready_nx  = 1'b0;
    dc_ready_nx  = 1'b0;
    err_nx       = err_timeout;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (dc_elig && (!ic_elig || prefer_dc)) begin
          state_nx = DC_BUSY;
          addr_nx  = dc_addr;
          wdata_nx = dc_we ? dc_wdata : '0;
          wren_nx  = dc_we;
          rden_nx  = !dc_we;
        end else if (ic_elig) begin
          state_nx = IC_BUSY;
          addr_nx  = ic_addr;
          wdata_nx = '0;
          wren_nx  = 1'b0;
          rden_nx  = 1'b1;
        end
      end
      IC_BUSY, DC_BUSY: begin
        if (mem_ready || expired) begin
          state_nx     = IDLE;
          wren_nx      = 1'b0;
          rden_nx      = 1'b0;
          prefer_dc_nx = (state == IC_BUSY);
          if (state == IC_BUSY) ic_ready_nx = 1'b1;
          else                  dc_ready_nx = 1'b1;
          if (mem_ready) begin
            // Writes complete without touching the requester's read block.
            if (!mem_wren) begin
              if (state == IC_BUSY) ic_rdata_nx = mem_data_out;
              else                  dc_rdata_nx = mem_data_out;
            end
          end else begin
            err_nx = 1'b1;
            if (state == IC_BUSY) ic_rdata_nx = '0;
            else                  dc_rdata_nx = '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      prefer_dc   <= 1'b1;
      mem_wren    <= 1'b0;
      mem_rden    <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      ic_rdata    <= '0;
      dc_rdata    <= '0;
      ic_ready    <= 1'b0;
      dc_ready    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      prefer_dc   <= prefer_dc_nx;
      mem_wren    <= wren_nx;
      mem_rden    <= rden_nx;
      mem_addr    <= addr_nx;
      mem_data_in <= wdata_nx;
      ic_rdata    <= ic_rdata_nx;
      dc_rdata    <= dc_rdata_nx;
      ic_ready    <= ic_ready_nx;
      dc_ready    <= dc_ready_nx;
      err_timeout <= err_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a latency-programmable
// block memory model, and a monitor that checks every ready pulse in order.
module tb_mem_arbiter;

  localparam int AW = 23;
  localparam int DW = 128;
  localparam logic [DW-1:0] A5 = {16{8'hA5}};
  localparam logic [DW-1:0] WD = 128'h0123456789ABCDEF0123456789ABCDEF;

  typedef struct {
    bit            dc;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0;
  logic [DW-1:0] dc_wdata = '0;
  logic          ic_ready, dc_ready, mem_wren, mem_rden, err_timeout;
  logic [DW-1:0] ic_rdata, dc_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  int   lat = 3;
  bit   hang = 1'b0;
  bit   stray_req = 1'b0, stray_ack;
  int   lat_cnt;
  logic [DW-1:0] mem[16];
  logic rdy_q = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ready(mem_ready),
    .err_timeout(err_timeout)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit dc, input logic [DW-1:0] data);
    exp_t e;
    e.dc   = dc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_wren"}, mem_wren, 0);
    check({pfx, "_rden"}, mem_rden, 0);
    check({pfx, "_addr"}, mem_addr, 0);
    check({pfx, "_wdata"}, mem_data_in, 0);
    check({pfx, "_ic_ready"}, ic_ready, 0);
    check({pfx, "_dc_ready"}, dc_ready, 0);
    check({pfx, "_ic_rdata"}, ic_rdata, 0);
    check({pfx, "_dc_rdata"}, dc_rdata, 0);
    check({pfx, "_err"}, err_timeout, 0);
  endtask

  // Waits at negedges for the requester's ready, then drops its request.
  task automatic wait_ready(input bit dc);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (dc ? dc_ready : ic_ready) got = 1'b1;
      else @(negedge clk);
    end
    check(dc ? "dc_ready_seen" : "ic_ready_seen", got, 1);
    if (dc) dc_req = 1'b0;
    else    ic_req = 1'b0;
  endtask

  // Block memory: asserts mem_ready after lat enabled cycles, restarting per access.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = A5;
    mem_ready    = 1'b0;
    mem_data_out = '0;
    lat_cnt      = 0;
    stray_ack    = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        mem_ready = 1'b1;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        lat_cnt   = 0;
      end else if (mem_rden || mem_wren) begin
        if (!hang) begin
          lat_cnt++;
          if (lat_cnt >= lat) begin
            if (mem_wren) mem[mem_addr[3:0]] = mem_data_in;
            else          mem_data_out = mem[mem_addr[3:0]];
            mem_ready = 1'b1;
          end
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  always @(posedge clk) rdy_q <= mem_ready;

  // Monitor: protocol invariants every cycle, scoreboard pop on each ready.
  initial begin
    logic          prev_en = 1'b0;
    logic          prev_wren = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      check("wren_rden_excl", mem_wren & mem_rden, 0);
      check("ready_excl", ic_ready & dc_ready, 0);
      if (rdy_q && rst_n) check("gap_after_ready", mem_wren | mem_rden, 0);
      if (prev_en && (mem_wren || mem_rden)) begin
        check("hold_addr", mem_addr, prev_addr);
        check("hold_data", mem_data_in, prev_data);
        check("hold_wren", mem_wren, prev_wren);
      end
      if (ic_ready || dc_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_who", dc_ready, e.dc);
          check("sb_rdata", e.dc ? dc_rdata : ic_rdata, e.data);
        end
      end
      prev_en   = mem_wren | mem_rden;
      prev_wren = mem_wren;
      prev_addr = mem_addr;
      prev_data = mem_data_in;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // I-cache read of a preloaded block
    push(0, A5);
    ic_addr = 23'h10;
    ic_req  = 1'b1;
    @(negedge clk);
    check("ic_rden", mem_rden, 1);
    check("ic_wren", mem_wren, 0);
    check("ic_addr", mem_addr, 23'h10);
    wait_ready(0);
    repeat (2) @(negedge clk);

    // D-cache write leaves dc_rdata untouched, then reads the block back
    push(1, '0);
    dc_addr  = 23'h4;
    dc_wdata = WD;
    dc_we    = 1'b1;
    dc_req   = 1'b1;
    @(negedge clk);
    check("dcw_wren", mem_wren, 1);
    check("dcw_rden", mem_rden, 0);
    check("dcw_wdata", mem_data_in, WD);
    wait_ready(1);
    @(negedge clk);
    push(1, WD);
    dc_we  = 1'b0;
    dc_req = 1'b1;
    @(negedge clk);
    check("dcr_rden", mem_rden, 1);
    check("dcr_wren", mem_wren, 0);
    check("dcr_wdata", mem_data_in, 0);
    wait_ready(1);
    repeat (2) @(negedge clk);

    // mem_ready while idle must not start or complete anything
    stray_req = ~stray_req;
    repeat (3) @(negedge clk);
    check("stray_rden", mem_rden, 0);
    check("stray_wren", mem_wren, 0);

    // After reset both requests rise together: D, I, D
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(1, WD);
    push(0, A5);
    push(1, WD);
    ic_addr = 23'h10;
    dc_addr = 23'h4;
    dc_we   = 1'b0;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    fork
      begin
        wait_ready(1);
        @(negedge clk);
        dc_req = 1'b1;
        wait_ready(1);
      end
      wait_ready(0);
    join
    repeat (2) @(negedge clk);

    // D was served last, so a simultaneous pair now goes to I first
    push(0, A5);
    push(1, WD);
    ic_req = 1'b1;
    dc_req = 1'b1;
    fork
      wait_ready(1);
      wait_ready(0);
    join
    repeat (2) @(negedge clk);

    // Memory never answers: abort after 64 busy cycles with zeroed read block
    hang = 1'b1;
    push(1, '0);
    dc_req = 1'b1;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (dc_ready) got = 1'b1;
      else if (mem_rden) n++;
    end
    check("to_ready_seen", got, 1);
    check("to_busy_cycles", n, 64);
    check("to_rden", mem_rden, 0);
    check("to_wren", mem_wren, 0);
    check("to_err", err_timeout, 1);
    dc_req = 1'b0;
    hang   = 1'b0;
    repeat (4) @(negedge clk);
    check("to_err_sticky", err_timeout, 1);
    push(0, A5);
    ic_req = 1'b1;
    wait_ready(0);
    check("to_err_after_ok", err_timeout, 1);
    repeat (2) @(negedge clk);

    // Reset in the middle of an I-cache read abandons it silently
    lat    = 10;
    ic_req = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rden", mem_rden, 1);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    @(negedge clk);
    ic_req = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("mid_held");
    rst_n = 1'b1;
    lat   = 3;
    @(negedge clk);
    push(0, A5);
    ic_req = 1'b1;
    wait_ready(0);

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
